// File: rtl/mtm_alu_pserializer.sv
// Serialises an ALU result (or an error report) into start/type/payload/stop frames.
// Normal packets carry DATA_BYTES data frames then a control frame with flags and CRC-3.
//
// state   | meaning
// IDLE    | line idle high, ready for a new result
// START   | start bit (0) on sout
// TYPE    | frame type bit on sout (0 data, 1 control)
// PAYLOAD | 8 payload bits on sout, MSB first
// STOP    | STOP_BITS stop bits (1) on sout
module mtm_alu_pserializer #(
    parameter int DATA_BYTES = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*DATA_BYTES-1:0] in_data,
    input  logic [3:0]              in_flags,
    input  logic                    in_err,
    input  logic [5:0]              in_err_code,
    output logic                    sout,
    output logic                    busy
);

    localparam int W = 8 * DATA_BYTES;

    typedef enum logic [2:0] {IDLE, START, TYPE, PAYLOAD, STOP} state_t;

    state_t       state;
    logic [W-1:0] data_q;
    logic [7:0]   pay_sh;
    logic [3:0]   flags_q;
    logic [2:0]   crc_q;
    logic         cur_type;
    logic [2:0]   bit_cnt;
    logic [1:0]   stop_cnt;
    logic [3:0]   byte_cnt;
    logic         accept;

    // Serial CRC-3 (x^3+x+1) over data, a zero separator bit, then the flags.
    function automatic logic [2:0] crc_calc(input logic [W-1:0] d, input logic [3:0] f);
        logic [W+4:0] msg;
        logic [2:0]   c;
        logic         fb;
        msg = {d, 1'b0, f};
        c   = 3'b000;
        for (int i = W + 4; i >= 0; i--) begin
            fb = c[2] ^ msg[i];
            c  = {c[1], c[0] ^ fb, fb};
        end
        return c;
    endfunction

    assign in_ready = rst && (state == IDLE);
    assign busy     = rst && (state != IDLE);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            sout     <= 1'b1;
            data_q   <= '0;
            pay_sh   <= '0;
            flags_q  <= '0;
            crc_q    <= '0;
            cur_type <= 1'b0;
            bit_cnt  <= '0;
            stop_cnt <= '0;
            byte_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    sout <= 1'b1;
                    if (accept) begin
                        state    <= START;
                        sout     <= 1'b0;
                        bit_cnt  <= '0;
                        stop_cnt <= '0;
                        byte_cnt <= '0;
                        flags_q  <= in_flags;
                        crc_q    <= crc_calc(in_data, in_flags);
                        if (in_err) begin
                            cur_type <= 1'b1;
                            pay_sh   <= {1'b1, in_err_code, ^in_err_code};
                            data_q   <= '0;
                        end else begin
                            cur_type <= 1'b0;
                            pay_sh   <= in_data[W-1 -: 8];
                            data_q   <= in_data << 8;
                        end
                    end
                end
                START: begin
                    sout  <= cur_type;
                    state <= TYPE;
                end
                TYPE: begin
                    sout    <= pay_sh[7];
                    pay_sh  <= {pay_sh[6:0], 1'b0};
                    bit_cnt <= '0;
                    state   <= PAYLOAD;
                end
                PAYLOAD: begin
                    if (bit_cnt == 3'd7) begin
                        sout     <= 1'b1;
                        bit_cnt  <= '0;
                        stop_cnt <= '0;
                        state    <= STOP;
                    end else begin
                        sout    <= pay_sh[7];
                        pay_sh  <= {pay_sh[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end
                STOP: begin
                    if (stop_cnt == 2'(STOP_BITS - 1)) begin
                        stop_cnt <= '0;
                        if (cur_type) begin
                            state    <= IDLE;
                            sout     <= 1'b1;
                            byte_cnt <= '0;
                            cur_type <= 1'b0;
                        end else begin
                            state <= START;
                            sout  <= 1'b0;
                            // After the last data byte the control frame follows.
                            if (byte_cnt == 4'(DATA_BYTES - 1)) begin
                                cur_type <= 1'b1;
                                pay_sh   <= {1'b0, flags_q, crc_q};
                                byte_cnt <= '0;
                            end else begin
                                pay_sh   <= data_q[W-1 -: 8];
                                data_q   <= data_q << 8;
                                byte_cnt <= byte_cnt + 4'd1;
                            end
                        end
                    end else begin
                        stop_cnt <= stop_cnt + 2'd1;
                        sout     <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    sout  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mtm_alu_pserializer.sv
// Directed bench for mtm_alu_pserializer: a 4-byte/1-stop instance and a 1-byte/2-stop instance.
module tb_mtm_alu_pserializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, in_err, sout, busy;
    logic [31:0] in_data;
    logic [3:0]  in_flags;
    logic [5:0]  in_err_code;

    logic        b_valid, b_ready, b_err, b_sout, b_busy;
    logic [7:0]  b_data;
    logic [3:0]  b_flags;
    logic [5:0]  b_code;

    mtm_alu_pserializer #(.DATA_BYTES(4), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_flags(in_flags), .in_err(in_err),
        .in_err_code(in_err_code), .sout(sout), .busy(busy)
    );

    mtm_alu_pserializer #(.DATA_BYTES(1), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready),
        .in_data(b_data), .in_flags(b_flags), .in_err(b_err),
        .in_err_code(b_code), .sout(b_sout), .busy(b_busy)
    );

    typedef struct {
        logic [31:0] data;
        logic [3:0]  flags;
        logic        err;
        logic [5:0]  code;
        logic [7:0]  ctrl;
    } vec_t;

    vec_t vecs[7];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Reference CRC-3 by polynomial long division of the message times x^3.
    function automatic logic [2:0] crc_ref(input logic [63:0] msg);
        logic [66:0] m;
        m = {msg, 3'b000};
        for (int i = 66; i >= 3; i--)
            if (m[i]) m[i -: 4] = m[i -: 4] ^ 4'b1011;
        return m[2:0];
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ready_timeout", in_ready, 1'b1);
    endtask

    task automatic send(input vec_t v);
        wait_ready();
        in_data     = v.data;
        in_flags    = v.flags;
        in_err      = v.err;
        in_err_code = v.code;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("accept_busy", busy, 1'b1);
    endtask

    task automatic capture_frame(input logic typ, input logic [7:0] pay, input string name,
                                 input int nstop, input bit second);
        logic [11:0] got;
        logic [11:0] exp;
        int          rdy;
        got = '0;
        rdy = 0;
        for (int b = 0; b < 10 + nstop; b++) begin
            @(negedge clk);
            got = {got[10:0], second ? b_sout : sout};
            if (second ? b_ready : in_ready) rdy++;
        end
        exp = (nstop == 1) ? {1'b0, 1'b0, typ, pay, 1'b1} : {1'b0, typ, pay, 2'b11};
        check(name, got, exp);
        check({name, "_ready_low"}, rdy, 0);
    endtask

    task automatic capture_packet(input logic [31:0] d, input logic err, input logic [7:0] ctrl);
        if (!err)
            for (int k = 0; k < 4; k++)
                capture_frame(1'b0, d[31-8*k -: 8], $sformatf("data_byte%0d", k), 1, 1'b0);
        capture_frame(1'b1, ctrl, "ctrl_frame", 1, 1'b0);
        @(negedge clk);
        check("idle_ready", in_ready, 1'b1);
        check("idle_sout", sout, 1'b1);
    endtask

    function automatic logic [7:0] ctrl_of(input logic [31:0] d, input logic [3:0] f);
        return {1'b0, f, crc_ref({d, 1'b0, f})};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog_timeout got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d1, d2;
        logic [3:0]  f1, f2;
        vec_t        v;

        vecs[0] = '{32'h0000_0000, 4'b0000, 1'b0, 6'd0, 8'h00};
        vecs[1] = '{32'h1234_5678, 4'b1010, 1'b0, 6'd0, 8'h00};
        vecs[1].ctrl = ctrl_of(32'h1234_5678, 4'b1010);
        vecs[2] = '{32'h0000_0000, 4'b0000, 1'b1, 6'b000111, 8'h8F};
        vecs[3] = '{32'h0000_0000, 4'b0001, 1'b0, 6'd0, 8'h0B};
        vecs[4] = '{32'h0000_0000, 4'b1000, 1'b0, 6'd0, 8'h45};
        vecs[5] = '{32'hFFFF_FFFF, 4'b1111, 1'b1, 6'b101010, 8'hD5};
        vecs[6] = '{32'hFFFF_FFFF, 4'b1111, 1'b0, 6'd0, 8'h00};
        vecs[6].ctrl = ctrl_of(32'hFFFF_FFFF, 4'b1111);

        rst = 1'b0; in_valid = 1'b0; in_data = '0; in_flags = '0; in_err = 1'b0; in_err_code = '0;
        b_valid = 1'b0; b_data = '0; b_flags = '0; b_err = 1'b0; b_code = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_sout", sout, 1'b1);
        check("rst_sout_b", b_sout, 1'b1);
        rst = 1'b1;
        #1;
        check("post_rst_ready", in_ready, 1'b1);
        @(negedge clk);
        check("post_rst_sout", sout, 1'b1);
        check("post_rst_busy", busy, 1'b0);

        for (int i = 0; i < 7; i++) begin
            send(vecs[i]);
            capture_packet(vecs[i].data, vecs[i].err, vecs[i].ctrl);
        end

        // in_valid held high: back-to-back packets with one idle bit, busy-time input changes ignored
        d1 = 32'hA5A5_5A5A; f1 = 4'b0011;
        d2 = 32'h0F1E_2D3C; f2 = 4'b1100;
        wait_ready();
        in_data = d1; in_flags = f1; in_err = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_data = 32'hDEAD_BEEF; in_flags = 4'b0101; in_err = 1'b1;
        capture_frame(1'b0, d1[31:24], "hold_byte0", 1, 1'b0);
        in_data = d2; in_flags = f2; in_err = 1'b0;
        for (int k = 1; k < 4; k++)
            capture_frame(1'b0, d1[31-8*k -: 8], $sformatf("hold_byte%0d", k), 1, 1'b0);
        capture_frame(1'b1, ctrl_of(d1, f1), "hold_ctrl", 1, 1'b0);
        @(negedge clk);
        check("hold_idle_ready", in_ready, 1'b1);
        check("hold_idle_sout", sout, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("hold_second_busy", busy, 1'b1);
        capture_packet(d2, 1'b0, ctrl_of(d2, f2));

        // reset during the 3rd payload bit of the second data frame
        send(vecs[1]);
        capture_frame(1'b0, 8'h12, "pre_rst_byte0", 1, 1'b0);
        repeat (5) @(negedge clk);
        check("pre_rst_bit", sout, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_sout", sout, 1'b1);
        check("mid_rst_ready", in_ready, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        rst = 1'b1;
        #1;
        check("after_rst_ready", in_ready, 1'b1);
        @(negedge clk);
        check("after_rst_sout", sout, 1'b1);
        send(vecs[3]);
        capture_packet(vecs[3].data, vecs[3].err, vecs[3].ctrl);

        // 1-byte, 2-stop-bit instance
        @(negedge clk);
        check("b_ready_idle", b_ready, 1'b1);
        b_data = 8'hA5; b_flags = 4'b0110; b_err = 1'b0; b_valid = 1'b1;
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        check("b_busy", b_busy, 1'b1);
        capture_frame(1'b0, 8'hA5, "b_data", 2, 1'b1);
        capture_frame(1'b1, {1'b0, 4'b0110, crc_ref({8'hA5, 1'b0, 4'b0110})}, "b_ctrl", 2, 1'b1);
        @(negedge clk);
        check("b_idle_ready", b_ready, 1'b1);
        check("b_idle_sout", b_sout, 1'b1);
        b_err = 1'b1; b_code = 6'b000111; b_valid = 1'b1;
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        capture_frame(1'b1, 8'h8F, "b_err", 2, 1'b1);
        @(negedge clk);
        check("b_err_idle_ready", b_ready, 1'b1);
        check("b_err_idle_sout", b_sout, 1'b1);

        v = vecs[0];
        send(v);
        capture_packet(v.data, v.err, v.ctrl);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mtm_alu_pserializer.md
MTM_ALU_PSERIALIZER -- requirements
Module: mtm_alu_pserializer

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 4, meaning the number of result data bytes per packet (legal 1..8).
REQ-002 SHALL have parameter STOP_BITS, default 1, meaning the number of stop bits per frame (legal 1..4).
REQ-003 SHALL have port clk, input, 1, system clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, result available.
REQ-006 SHALL have port in_ready, output, 1, block can accept a result.
REQ-007 SHALL have port in_data, input, 8*DATA_BYTES, result word.
REQ-008 SHALL have port in_flags, input, 4, {carry, overflow, zero, negative}.
REQ-009 SHALL have port in_err, input, 1, send an error packet instead of a result.
REQ-010 SHALL have port in_err_code, input, 6, error code for the error packet.
REQ-011 SHALL have port sout, output, 1, registered serial line, idle high.
REQ-012 SHALL have port busy, output, 1, packet in progress; equals !in_ready while rst=1.

Function
REQ-013 SHALL accept a transfer only in a cycle with in_valid=1 and in_ready=1, and SHALL sample in_data, in_flags, in_err and in_err_code only in that cycle.
REQ-014 SHALL drive in_ready=1 only in state IDLE with rst=1; in_valid while in_ready=0 SHALL have no effect.
REQ-015 SHALL send each frame as: start bit 0, type bit (0 data, 1 control), 8 payload bits MSB first, then STOP_BITS bits of 1, one bit per clk.
REQ-016 SHALL send a normal packet (in_err=0) as DATA_BYTES data frames, most-significant byte first, followed by one control frame with payload {1'b0, in_flags[3:0], crc[2:0]}.
REQ-017 SHALL compute crc as CRC-3 with polynomial x^3+x+1 and init 3'b000, over in_data MSB first, then 1'b0, then in_flags[3:0] MSB first; the value SHALL be ready before the control payload starts.
REQ-018 SHALL send an error packet (in_err=1) as one control frame only, with payload {1'b1, in_err_code[5:0], ^in_err_code}.
REQ-019 SHALL drive the start bit of the first frame on sout in the cycle after the accept cycle.
REQ-020 SHALL start each next frame's start bit in the cycle directly after the previous frame's last stop bit, with no idle gap inside a packet.
REQ-021 SHALL return to IDLE after the last stop bit of the control frame, with in_ready=1 in the following cycle and sout=1 while idle.
REQ-022 SHALL run state machine states IDLE, START, TYPE, PAYLOAD, STOP: IDLE->START on accept; START->TYPE; TYPE->PAYLOAD; PAYLOAD->STOP after 8 bits; STOP->START when frames remain, else STOP->IDLE after STOP_BITS cycles.
REQ-023 SHALL take exactly (DATA_BYTES+1)*(10+STOP_BITS) cycles per normal packet and 10+STOP_BITS per error packet, counted from the first start bit to the last stop bit.
REQ-024 SHALL make an accept in the first IDLE cycle after a packet produce exactly one idle 1 cycle between packets.
REQ-025 SHALL make bit, byte and stop counters wrap to 0 at each frame or packet boundary, with no residue carried into the next packet.

Reset
REQ-026 SHALL, on rst=0 at a clk edge, set sout=1, the state to IDLE, and all counters, the crc and the packet registers to 0, including in the middle of a packet.
REQ-027 SHALL hold in_ready=0 and busy=0 while rst=0, and SHALL assert in_ready=1 in the first cycle with rst=1.
REQ-028 SHALL discard a packet aborted by reset; after reset no partial frame SHALL be resumed.

Verification
REQ-029 SHALL cover: DATA_BYTES=4, STOP_BITS=1, in_data=0, in_flags=0 -> five frames, each 0,type,00000000,1, with types 0,0,0,0,1; control payload 0x00; 55 cycles.
REQ-030 SHALL cover: in_data=0x12345678, in_flags=4'b1010 -> data payloads 0x12,0x34,0x56,0x78 in order; control payload {0,1010,crc} matching the reference CRC-3 model.
REQ-031 SHALL cover: in_err=1, in_err_code=6'b000111 -> single frame 0,1,10001111,1; in_ready=1 after 11 cycles.
REQ-032 SHALL cover: in_valid held at 1 continuously -> a second packet accepted in the cycle in_ready rises; exactly one idle 1 between packets; in_data changes while busy are ignored.
REQ-033 SHALL cover: rst=0 asserted at the 3rd payload bit of data byte 2 -> sout=1 next cycle; in_ready=1 in the first cycle after rst returns to 1; the next packet is transmitted cleanly.
REQ-034 SHALL cover: DATA_BYTES=1, STOP_BITS=2 -> two frames of 12 cycles each, with the stop pair 1,1 after each frame.
